// File: rtl/dbfs_mul_share_arb.sv
// dbfs_mul_share_arb: round-robin share of one pipelined 37s x 43u multiplier with tag realignment and a credit-protected result FIFO.
// Optional DBFS_ARB_CH0_PRIO_EN gives requester 0 absolute priority.
module dbfs_mul_share_arb #(
    parameter int N_REQ      = 4,
    parameter int ID_W       = 2,
    parameter int MUL_LAT    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                ap_clk,
    input  logic                ap_rst_n,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [N_REQ*37-1:0] req_a,
    input  logic [N_REQ*43-1:0] req_b,
    output logic                mul_ce,
    output logic [36:0]         mul_din0,
    output logic [42:0]         mul_din1,
    input  logic [78:0]         mul_dout,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [78:0]         res_data,
    output logic [ID_W-1:0]     res_id
);
    localparam int PD = MUL_LAT + 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + PD + 1) + 1;

    logic                             ce_q;
    logic [ID_W-1:0]                  rr_q, rr_d;
    logic [36:0]                      din0_q;
    logic [42:0]                      din1_q;
    logic [PD-1:0]                    tag_v_q;
    logic [PD-1:0][ID_W-1:0]          tag_id_q;
    logic [FIFO_DEPTH-1:0][78:0]      dat_q;
    logic [FIFO_DEPTH-1:0][ID_W-1:0]  fid_q;
    logic [AW-1:0]                    wr_q, rd_q;
    logic [AW:0]                      cnt_q;
    logic [N_REQ-1:0]                 rr_mask;
    logic                             p0, rr_hit, room, grant, push, pop;
    logic [ID_W-1:0]                  rr_id, gnt_id;
    logic [CW-1:0]                    inflight;

`ifdef DBFS_ARB_CH0_PRIO_EN
    assign p0      = req_valid[0];
    assign rr_mask = {req_valid[N_REQ-1:1], 1'b0};
`else
    assign p0      = 1'b0;
    assign rr_mask = req_valid;
`endif

    // scan from rr_q + N_REQ - 1 down to rr_q so the nearest valid requester wins
    always_comb begin
        int idx;
        idx    = 0;
        rr_hit = 1'b0;
        rr_id  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_q) + k;
            idx = (idx >= N_REQ) ? idx - N_REQ : idx;
            if (rr_mask[idx]) begin
                rr_hit = 1'b1;
                rr_id  = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        inflight = '0;
        for (int k = 0; k < PD; k++)
            inflight = inflight + CW'(tag_v_q[k]);
    end

    // every issued product is either in the tag pipe or in the FIFO, so this reserves its slot
    assign room      = (CW'(cnt_q) + inflight) < CW'(FIFO_DEPTH);
    assign grant     = ce_q & room & (p0 | rr_hit);
    assign gnt_id    = p0 ? '0 : rr_id;
    assign rr_d      = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
    assign req_ready = grant ? (N_REQ'(1) << gnt_id) : '0;

    assign push      = tag_v_q[PD-1];
    assign res_valid = cnt_q != '0;
    assign pop       = res_valid & res_ready;
    assign res_data  = dat_q[rd_q];
    assign res_id    = fid_q[rd_q];
    assign mul_ce    = ce_q;
    assign mul_din0  = din0_q;
    assign mul_din1  = din1_q;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ce_q     <= 1'b0;
            rr_q     <= '0;
            din0_q   <= '0;
            din1_q   <= '0;
            tag_v_q  <= '0;
            tag_id_q <= '0;
            dat_q    <= '0;
            fid_q    <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
        end else begin
            ce_q     <= 1'b1;
            if (grant) begin
                din0_q <= req_a[37*gnt_id +: 37];
                din1_q <= req_b[43*gnt_id +: 43];
                if (!p0) rr_q <= rr_d;
            end
            tag_v_q  <= {tag_v_q[PD-2:0], grant};
            tag_id_q <= {tag_id_q[PD-2:0], gnt_id};
            if (push) begin
                dat_q[wr_q] <= mul_dout;
                fid_q[wr_q] <= tag_id_q[PD-1];
                wr_q        <= wr_q + AW'(1);
            end
            if (pop) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_dbfs_mul_share_arb.sv
// tb_dbfs_mul_share_arb: randomized bench with an external multiplier model and a
// scoreboard of outstanding products, grant order and result timing.
module tb_dbfs_mul_share_arb;
    localparam int N = 4, IW = 2, LAT = 2, DEPTH = 4;

    logic           ap_clk = 1'b0, ap_rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0, req_ready;
    logic [N*37-1:0] req_a = '0;
    logic [N*43-1:0] req_b = '0;
    logic           mul_ce;
    logic [36:0]    mul_din0;
    logic [42:0]    mul_din1;
    logic [78:0]    mul_dout, mp1, mp2;
    logic           res_valid, res_ready = 1'b0;
    logic [78:0]    res_data;
    logic [IW-1:0]  res_id;

    typedef struct {logic [78:0] p; int id; int rdy;} ent_t;
    ent_t exp_q[$];
    int n_cmp = 0, n_bad = 0;
    int rr = 0, outstanding = 0, cyc = 0, n_dut_gr = 0, w;
    bit run = 0;
    logic [78:0] last_data;
    logic [IW-1:0] last_id;

    dbfs_mul_share_arb dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1),
        .mul_dout(mul_dout), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id)
    );

    always #5 ap_clk = ~ap_clk;

    function automatic logic [78:0] prod(input logic [36:0] a, input logic [42:0] b);
        logic signed [78:0] ax, bx;
        ax = $signed(a);
        bx = $signed({36'b0, b});
        return ax * bx;
    endfunction

    // external multiplier: never reset, so stale products keep flowing after a reset
    always @(posedge ap_clk) if (mul_ce) begin
        mp1 <= prod(mul_din0, mul_din1);
        mp2 <= mp1;
    end
    assign mul_dout = mp2;

    task automatic chk(input string tag, input logic [78:0] act, input logic [78:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int pick();
        if (!run || outstanding >= DEPTH) return -1;
`ifdef DBFS_ARB_CH0_PRIO_EN
        if (req_valid[0]) return 0;
        for (int k = 0; k < N; k++) if ((rr + k) % N != 0 && req_valid[(rr + k) % N]) return (rr + k) % N;
`else
        for (int k = 0; k < N; k++) if (req_valid[(rr + k) % N]) return (rr + k) % N;
`endif
        return -1;
    endfunction

    task automatic cycle(output int wo);
        bit ev;
        ent_t e;
        @(negedge ap_clk);
        wo = pick();
        chk("req_ready", 79'(req_ready), (wo < 0) ? 79'(0) : 79'(1) << wo);
        chk("mul_ce", 79'(mul_ce), 79'(run));
        ev = exp_q.size() > 0 && exp_q[0].rdy <= cyc;
        chk("res_valid", 79'(res_valid), 79'(ev));
        if (ev) begin
            chk("res_data", res_data, exp_q[0].p);
            chk("res_id", 79'(res_id), 79'(exp_q[0].id));
        end
        if (req_ready != 0) n_dut_gr++;
        if (res_valid && res_ready) begin
            last_data = res_data;
            last_id   = res_id;
        end
        if (wo >= 0) begin
            e.p = prod(req_a[37*wo +: 37], req_b[43*wo +: 43]);
            e.id = wo;
            e.rdy = cyc + LAT + 2;
            exp_q.push_back(e);
            outstanding++;
`ifdef DBFS_ARB_CH0_PRIO_EN
            if (wo != 0) rr = (wo + 1) % N;
`else
            rr = (wo + 1) % N;
`endif
        end
        if (ev && res_ready) begin
            void'(exp_q.pop_front());
            outstanding--;
        end
        run = 1;
        cyc++;
        @(posedge ap_clk);
        #1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        outstanding = 0;
        rr = 0;
        run = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 79'(req_ready), 79'(0));
        chk({tag, "_ce"}, 79'(mul_ce), 79'(0));
        chk({tag, "_din0"}, 79'(mul_din0), 79'(0));
        chk({tag, "_din1"}, 79'(mul_din1), 79'(0));
        chk({tag, "_rvalid"}, 79'(res_valid), 79'(0));
        chk({tag, "_rdata"}, res_data, 79'(0));
        chk({tag, "_rid"}, 79'(res_id), 79'(0));
    endtask

    task automatic issue_one(input logic [36:0] a, input logic [42:0] b);
        int g;
        g = -1;
        req_valid = 4'b0001;
        req_a[36:0] = a;
        req_b[42:0] = b;
        for (int k = 0; k < 6 && g != 0; k++) cycle(g);
        if (g != 0) chk("issue_timeout", 79'(0), 79'(1));
        req_valid = '0;
    endtask

    task automatic randomize_ops();
        for (int i = 0; i < N; i++) begin
            req_a[37*i +: 37] = 37'({$urandom(), $urandom()});
            req_b[43*i +: 43] = 43'({$urandom(), $urandom()});
            if ($urandom_range(0, 9) == 0) req_a[37*i +: 37] = {1'b1, 36'b0};
            if ($urandom_range(0, 9) == 0) req_b[43*i +: 43] = '1;
        end
    endtask

    initial begin
        logic signed [127:0] wa, wb, wp;
        int base;
        repeat (2) @(posedge ap_clk);
        #1;
        req_valid = 4'b1111;
        #1;
        chk_reset_outputs("rst");
        req_valid = '0;
        ap_rst_n = 1'b1;
        model_reset();

        // single request, then drain
        res_ready = 1'b1;
        last_data = '0;
        issue_one(-37'sd5, 43'd7);
        repeat (6) cycle(w);
        chk("t1_data", last_data, -79'sd35);
        chk("t1_id", 79'(last_id), 79'(0));

        // all requesters valid, continuous drain
        req_valid = 4'b1111;
        repeat (16) begin randomize_ops(); cycle(w); end
        req_valid = '0;
        repeat (8) cycle(w);

        // operand extremes
        last_data = '0;
        issue_one({1'b1, 36'b0}, '1);
        repeat (6) cycle(w);
        wa = -(128'sd1 <<< 36);
        wb = (128'sd1 <<< 43) - 128'sd1;
        wp = wa * wb;
        chk("t3_data", last_data, wp[78:0]);

        // back-pressure: exactly DEPTH grants, then resume
        res_ready = 1'b0;
        req_valid = 4'b1111;
        base = n_dut_gr;
        repeat (10) begin randomize_ops(); cycle(w); end
        chk("bp_grants", 79'(n_dut_gr - base), 79'(DEPTH));
        res_ready = 1'b1;
        repeat (10) begin randomize_ops(); cycle(w); end
        req_valid = '0;
        repeat (8) cycle(w);

        // reset with products in flight
        req_valid = 4'b1111;
        repeat (2) begin randomize_ops(); cycle(w); end
        #1 ap_rst_n = 1'b0;
        #1 chk_reset_outputs("mid");
        model_reset();
        repeat (2) @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
        req_valid = '0;
        repeat (10) cycle(w);

        // randomized traffic
        repeat (1500) begin
            req_valid = N'($urandom());
            res_ready = $urandom_range(0, 3) != 0;
            randomize_ops();
            cycle(w);
        end
        req_valid = '0;
        res_ready = 1'b1;
        repeat (10) cycle(w);
        chk("drained", 79'(exp_q.size()), 79'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
